multi_motor_pwm_ctrl: RTL and testbench

N-channel successor to the single mini-motor PWM/direction/overcurrent path. It generates one shared PWM timebase. Each channel has its own duty, direction, dead-time-protected reversal and overcurrent fault latch with hysteresis. It sits between the board switch/host decode logic and the H-bridge pins, and exports per-channel fault status for the seven-segment display logic.

---
 rtl/motor_ctrl_pkg.sv | 23 ++
 rtl/motor_chan.sv | 117 +++++++++++
 rtl/multi_motor_pwm_ctrl.sv | 68 ++++++
 tb/tb_multi_motor_pwm_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and width helpers for the multi-channel motor PWM block.
// No ports: channel state encoding, period length and counter width helpers.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DEAD  = 2'd1,
    FAULT = 2'd2
  } chan_state_e;

  function automatic int period_ticks(input int dw);
    return (1 << dw) - 1;
  endfunction

  // Ticks per PWM period at the default 7-bit duty resolution.
  localparam int PERIOD_TICKS = period_ticks(7);

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/motor_chan.sv
// One motor channel: oc synchronizers, duty/dir sampling, RUN/DEAD/FAULT FSM.
// In: clk, rst_n, wrap, cnt, duty, dir, oc_set, oc_clr. Out: fwd, rev, fault.
module motor_chan
  import motor_ctrl_pkg::*;
#(
  parameter int DUTY_W     = 7,
  parameter int DEAD_PER   = 2,
  parameter int FAULT_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrap,
  input  logic [DUTY_W-1:0] cnt,
  input  logic [DUTY_W-1:0] duty,
  input  logic              dir,
  input  logic              oc_set,
  input  logic              oc_clr,
  output logic              fwd,
  output logic              rev,
  output logic              fault
);

  localparam int DW = cnt_w(DEAD_PER);
  localparam int HW = cnt_w(FAULT_HOLD + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEAD_PER - 1);
  localparam logic [HW-1:0] H_MAX = HW'(FAULT_HOLD);

  chan_state_e state, state_n;
  logic [1:0] set_sync, clr_sync;
  logic [DUTY_W-1:0] duty_q;
  logic dir_q, dir_q_n, dir_req;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic oc_s, oc_c, samp_dir, pwm;

  assign oc_s = set_sync[1];
  assign oc_c = clr_sync[1];
  // wrap is the edge that starts a new period, so the
  // value sampled there is visible in the same decision.
  assign samp_dir = wrap ? dir : dir_req;
  assign pwm = cnt < duty_q;

  always_comb begin
    state_n = state;
    dir_q_n = dir_q;
    dcnt_n  = dcnt;
    hcnt_n  = hcnt;
    unique case (state)
      RUN: begin
        if (oc_s) begin
          state_n = FAULT;
          hcnt_n  = '0;
        end else if (samp_dir != dir_q) begin
          state_n = DEAD;
          dcnt_n  = '0;
        end
      end
      DEAD: begin
        if (oc_s) begin
          state_n = FAULT;
          hcnt_n  = '0;
        end else if (wrap) begin
          if (dcnt == D_LAST) begin
            state_n = RUN;
            dir_q_n = samp_dir;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
      end
      FAULT: begin
        if (oc_s) begin
          hcnt_n = '0;
        end else if (hcnt == H_MAX && oc_c) begin
          // Re-drive only after a full dead interval.
          state_n = DEAD;
          dcnt_n  = '0;
        end else if (wrap && hcnt != H_MAX) begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_sync <= '0;
      clr_sync <= '0;
      state    <= RUN;
      dir_q    <= 1'b0;
      dir_req  <= 1'b0;
      duty_q   <= '0;
      dcnt     <= '0;
      hcnt     <= '0;
      fwd      <= 1'b0;
      rev      <= 1'b0;
      fault    <= 1'b0;
    end else begin
      set_sync <= {set_sync[0], oc_set};
      clr_sync <= {clr_sync[0], oc_clr};
      state    <= state_n;
      dir_q    <= dir_q_n;
      dcnt     <= dcnt_n;
      hcnt     <= hcnt_n;
      if (wrap) begin
        duty_q  <= duty;
        dir_req <= dir;
      end
      fwd   <= (state == RUN) && !dir_q && pwm;
      rev   <= (state == RUN) && dir_q && pwm;
      fault <= (state == FAULT);
    end
  end

endmodule

// File: rtl/multi_motor_pwm_ctrl.sv
// Shared PWM timebase (prescaler, cnt, period_start) driving N motor channels.
// In: CLK, RESET_N, duty, dir, oc_set, oc_clr. Out: motor_fwd/rev, fault, period_start.
module multi_motor_pwm_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DUTY_W     = 7,
  parameter int PRESCALE   = 100,
  parameter int DEAD_PER   = 2,
  parameter int FAULT_HOLD = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [N_CH*DUTY_W-1:0] duty,
  input  logic [N_CH-1:0]        dir,
  input  logic [N_CH-1:0]        oc_set,
  input  logic [N_CH-1:0]        oc_clr,
  output logic [N_CH-1:0]        motor_fwd,
  output logic [N_CH-1:0]        motor_rev,
  output logic [N_CH-1:0]        fault,
  output logic                   period_start
);

  localparam int PW = cnt_w(PRESCALE);
  localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] C_MAX =
    DUTY_W'(period_ticks(DUTY_W) - 1);

  logic [PW-1:0] psc;
  logic [DUTY_W-1:0] cnt;
  logic tick, wrap;

  assign tick = (psc == P_MAX);
  assign wrap = tick && (cnt == C_MAX);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      psc          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      psc <= tick ? '0 : psc + 1'b1;
      if (tick) cnt <= (cnt == C_MAX) ? '0 : cnt + 1'b1;
      period_start <= wrap;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_chan #(
      .DUTY_W    (DUTY_W),
      .DEAD_PER  (DEAD_PER),
      .FAULT_HOLD(FAULT_HOLD)
    ) u_chan (
      .clk   (CLK),
      .rst_n (RESET_N),
      .wrap  (wrap),
      .cnt   (cnt),
      .duty  (duty[i*DUTY_W +: DUTY_W]),
      .dir   (dir[i]),
      .oc_set(oc_set[i]),
      .oc_clr(oc_clr[i]),
      .fwd   (motor_fwd[i]),
      .rev   (motor_rev[i]),
      .fault (fault[i])
    );
  end

endmodule

// File: tb/tb_multi_motor_pwm_ctrl.sv
// Directed bench for multi_motor_pwm_ctrl: 2 channels, PRESCALE=1, 127-tick period.
// Counts per-period pin highs and checks them against hand-computed values.
module tb_multi_motor_pwm_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [13:0] duty;
  logic [1:0]  dir, oc_set, oc_clr;
  logic [1:0]  motor_fwd, motor_rev, fault;
  logic        period_start;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;
  int f_cnt[2];
  int r_cnt[2];
  int fl_cnt[2];
  int n_ps, n_f1, lows;

  multi_motor_pwm_ctrl #(
    .N_CH(2), .DUTY_W(7), .PRESCALE(1),
    .DEAD_PER(2), .FAULT_HOLD(4)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .duty        (duty),
    .dir         (dir),
    .oc_set      (oc_set),
    .oc_clr      (oc_clr),
    .motor_fwd   (motor_fwd),
    .motor_rev   (motor_rev),
    .fault       (fault),
    .period_start(period_start)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if ((motor_fwd & motor_rev) != 2'b00) both_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int c = 0; c < 2; c++) begin
      f_cnt[c] = 0; r_cnt[c] = 0; fl_cnt[c] = 0;
    end
  endtask

  task automatic sample();
    for (int c = 0; c < 2; c++) begin
      f_cnt[c]  += int'(motor_fwd[c]);
      r_cnt[c]  += int'(motor_rev[c]);
      fl_cnt[c] += int'(fault[c]);
    end
  endtask

  // Advance to the next negedge with period_start high.
  task automatic wait_ps();
    bit seen = 0;
    clear();
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge CLK);
      sample();
      if (period_start) seen = 1;
    end
    check("ps_seen", int'(seen), 1);
  endtask

  // Starting at a period_start negedge: the 127 samples cover the pin
  // response to cnt 0..126 of that period, ending on the next start.
  task automatic measure(input int chg_idx, input logic [1:0] chg_dir);
    clear();
    for (int i = 0; i < 127; i++) begin
      @(negedge CLK);
      sample();
      if (i == chg_idx) dir = chg_dir;
    end
  endtask

  // Count period starts seen while fault[1] stays high.
  task automatic count_fault_ps();
    int k = 0;
    n_ps = 0; n_f1 = 0;
    while (fault[1] && k < 3000) begin
      @(negedge CLK);
      k++;
      if (fault[1] && period_start) n_ps++;
      n_f1 += int'(motor_fwd[1]);
    end
    check("fault_cleared", int'(fault[1]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0;
    duty = {7'd64, 7'd32};
    dir = 2'b00; oc_set = 2'b00; oc_clr = 2'b00;
    repeat (3) @(negedge CLK);
    check("rst_fwd", int'(motor_fwd), 0);
    check("rst_rev", int'(motor_rev), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_ps", int'(period_start), 0);
    RESET_N = 1'b1;

    wait_ps();
    check("pre_samp_fwd0", f_cnt[0], 0);
    check("pre_samp_fwd1", f_cnt[1], 0);
    measure(-1, 2'b00);
    check("d32_fwd0", f_cnt[0], 32);
    check("d32_rev0", r_cnt[0], 0);
    check("d64_fwd1", f_cnt[1], 64);
    measure(-1, 2'b00);
    check("d32_fwd0_b", f_cnt[0], 32);

    duty[6:0] = 7'd0;
    measure(-1, 2'b00);
    check("mid_chg_fwd0", f_cnt[0], 32);
    measure(-1, 2'b00);
    check("d0_fwd0", f_cnt[0], 0);
    check("d0_rev0", r_cnt[0], 0);

    duty[6:0] = 7'd127;
    measure(-1, 2'b00);
    check("d127_lag", f_cnt[0], 0);
    measure(-1, 2'b00);
    check("d127_fwd0", f_cnt[0], 127);
    measure(-1, 2'b00);
    check("d127_fwd0_b", f_cnt[0], 127);

    duty[6:0] = 7'd32;
    measure(-1, 2'b00);
    check("d32_reload", f_cnt[0], 127);

    measure(60, 2'b01);
    check("rev_req_fwd0", f_cnt[0], 32);
    check("rev_req_rev0", r_cnt[0], 0);
    measure(-1, 2'b01);
    check("dead1_fwd0", f_cnt[0], 0);
    check("dead1_rev0", r_cnt[0], 0);
    check("dead1_fwd1", f_cnt[1], 64);
    measure(-1, 2'b01);
    check("dead2_fwd0", f_cnt[0], 0);
    check("dead2_rev0", r_cnt[0], 0);
    measure(-1, 2'b01);
    check("rev_fwd0", f_cnt[0], 0);
    check("rev_rev0", r_cnt[0], 32);

    oc_clr = 2'b10;
    repeat (10) @(negedge CLK);
    check("pre_oc_fwd1", int'(motor_fwd[1]), 1);
    oc_set = 2'b10;
    @(negedge CLK);
    oc_set = 2'b00;
    repeat (3) @(negedge CLK);
    check("oc_lat_fwd1", int'(motor_fwd[1]), 0);
    check("oc_lat_fault1", int'(fault[1]), 1);
    count_fault_ps();
    check("hold_ps", n_ps, 4);
    check("fault_fwd1", n_f1, 0);
    wait_ps();
    check("post_flt_dead_a", f_cnt[1], 0);
    measure(-1, 2'b01);
    check("post_flt_dead_b", f_cnt[1], 0);
    check("ch0_unaffected", r_cnt[0], 32);
    measure(-1, 2'b01);
    check("rerun_fwd1", f_cnt[1], 64);
    check("ch0_unaffected_b", r_cnt[0], 32);

    repeat (10) @(negedge CLK);
    oc_set = 2'b10;
    for (int k = 0; k < 20 && !fault[1]; k++) @(negedge CLK);
    check("flt2_on", int'(fault[1]), 1);
    lows = 0;
    for (int p = 0; p < 6; p++) begin
      wait_ps();
      lows += f_cnt[1] + r_cnt[1];
      if (!fault[1]) lows++;
    end
    check("flt2_held", lows, 0);
    repeat (10) @(negedge CLK);
    oc_set = 2'b00;
    count_fault_ps();
    check("flt2_restart_ps", n_ps, 4);

    oc_set = 2'b10;
    wait_ps();
    wait_ps();
    check("flt3_on", int'(fault[1]), 1);
    repeat (5) @(negedge CLK);
    check("pre_rst_rev0", int'(motor_rev[0]), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_fwd", int'(motor_fwd), 0);
    check("arst_rev", int'(motor_rev), 0);
    check("arst_fault", int'(fault), 0);
    check("arst_ps", int'(period_start), 0);
    oc_set = 2'b00; oc_clr = 2'b00; dir = 2'b00;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    wait_ps();
    check("rel_fwd0", f_cnt[0], 0);
    check("rel_fault1", fl_cnt[1], 0);
    measure(-1, 2'b00);
    check("rel_run_fwd0", f_cnt[0], 32);
    check("rel_run_rev0", r_cnt[0], 0);
    check("rel_run_fwd1", f_cnt[1], 64);
    check("rel_no_fault", fl_cnt[1], 0);

    check("no_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
